// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: HI/LO register file and sequencer around a pipelined unsigned 32x32 multiplier.
// Signed operands are reduced to magnitudes; the sign is restored after the multiplier latency.
module mult_hilo_unit #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_r,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(MUL_LATENCY + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q, acc_q, busy_q, done_q;
    logic [31:0]    mul_a_q, mul_b_q, hi_q, lo_q;
    logic [31:0]    mag_a, mag_b;
    logic [63:0]    prod, hilo_d;

    always_comb begin
        mag_a  = (op[0] && a[31]) ? -a : a;
        mag_b  = (op[0] && b[31]) ? -b : b;
        prod   = neg_q ? -mul_r : mul_r;
        hilo_d = acc_q ? {hi_q, lo_q} + prod : prod;
    end

    // MT writes share the idle cycle with an accepted start, so they become the accumulate base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    mul_a_q <= mag_a;
                    mul_b_q <= mag_b;
                    neg_q   <= op[0] & (a[31] ^ b[31]);
                    acc_q   <= op[1];
                    cnt_q   <= CW'(MUL_LATENCY);
                    busy_q  <= 1'b1;
                    state_q <= WAIT;
                end
                if (wr_hi) hi_q <= wr_data;
                if (wr_lo) lo_q <= wr_data;
            end else if (cnt_q == '0) begin
                {hi_q, lo_q} <= hilo_d;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule
